// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the B-type condition selected by the
// one-hot funct3 decode, computes the redirect target, flags mispredictions
// and trains a direct-mapped table of 2-bit bimodal counters that fetch
// reads combinationally. PIPE selects a registered or combinational result.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PIPE      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      decoded_f3,
  input  logic            B,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [2:0]      comp_code,
  output logic            illegal
);

  localparam int IDX = $clog2(BHT_DEPTH);

  // Everything the retirement side needs, including where to train.
  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [2:0]      comp_code;
    logic            illegal;
    logic            train;
    logic [IDX-1:0]  idx;
  } result_t;

  result_t    res;
  result_t    out_r;
  logic       out_v;
  logic       bad;
  logic       cond;
  logic [2:0] code;
  logic [1:0] bht [BHT_DEPTH];
  logic       retire;

  // PC alignment bits and bits above the table index never select a counter.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0]};

  // Decode the comparison, evaluate it and build the full result.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned and infer a latch.
    res  = '0;
    cond = 1'b0;
    code = 3'd0;
    bad  = B && (decoded_f3[2] || decoded_f3[3] || ((decoded_f3 & 8'hF3) == 8'h00));
    if (!B)                 code = 3'd0;
    else if (bad)           code = 3'd7;
    else if (decoded_f3[0]) code = 3'd0;
    else if (decoded_f3[1]) code = 3'd1;
    else if (decoded_f3[4]) code = 3'd2;
    else if (decoded_f3[5]) code = 3'd3;
    else if (decoded_f3[6]) code = 3'd4;
    else                    code = 3'd5;
    case (code)
      3'd0:    cond = (rs1 == rs2);
      3'd1:    cond = (rs1 != rs2);
      3'd2:    cond = ($signed(rs1) <  $signed(rs2));
      3'd3:    cond = ($signed(rs1) >= $signed(rs2));
      3'd4:    cond = (rs1 <  rs2);
      3'd5:    cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
    res.taken       = B && !bad && cond;
    res.mispredict  = res.taken != in_pred_taken;
    res.redirect_pc = res.taken ? (pc + imm) : (pc + XLEN'(4));
    res.comp_code   = code;
    res.illegal     = bad;
    res.train       = B && !bad;
    res.idx         = pc[IDX+1:2];
  end

  if (PIPE != 0) begin : g_pipe
    result_t r_q;
    logic    v_q;
    logic    accept;

    assign in_ready = (!v_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Single output register: flush wins, then capture, then drain.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
        v_q <= 1'b0;
        r_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (accept) begin
        v_q <= 1'b1;
        r_q <= res;
      end else if (out_ready) begin
        v_q <= 1'b0;
      end
    end

    assign out_v = v_q;
    assign out_r = r_q;
  end else begin : g_comb
    assign in_ready = out_ready && !flush;
    assign out_v    = in_valid && !flush;
    assign out_r    = res;
  end

  assign out_valid   = out_v;
  assign taken       = out_r.taken;
  assign mispredict  = out_r.mispredict;
  assign redirect_pc = out_r.redirect_pc;
  assign comp_code   = out_r.comp_code;
  assign illegal     = out_r.illegal;

  assign retire = out_v && out_ready && !flush && out_r.train;

  // Bimodal counters: reset to weakly not-taken, trained on retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this table is deliberately reset; prediction state must start
      // from a known weakly-not-taken value, unlike a plain data memory.
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'd1;
    end else if (retire) begin
      if (out_r.taken) begin
        if (bht[out_r.idx] != 2'd3) bht[out_r.idx] <= bht[out_r.idx] + 2'd1;
      end else begin
        if (bht[out_r.idx] != 2'd0) bht[out_r.idx] <= bht[out_r.idx] - 2'd1;
      end
    end
  end

  assign pred_taken = bht[lookup_pc[IDX+1:2]][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: a registered (PIPE=1) and a combinational (PIPE=0)
// instance share stimulus; results are compared against a table of
// hand-computed vectors, hand-written sequences and a behavioural model.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, b, in_pred_taken, flush, out_ready;
  logic [31:0] lookup_pc, rs1, rs2, pc, imm;
  logic [7:0]  decoded_f3;

  logic        p_pred, p_in_ready, p_out_valid, p_taken, p_mis, p_ill;
  logic [31:0] p_redir;
  logic [2:0]  p_code;
  logic        c_pred, c_in_ready, c_out_valid, c_taken, c_mis, c_ill;
  logic [31:0] c_redir;
  logic [2:0]  c_code;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .PIPE(1)) u_dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(p_pred),
    .in_valid(in_valid), .in_ready(p_in_ready), .decoded_f3(decoded_f3), .B(b),
    .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .in_pred_taken(in_pred_taken),
    .flush(flush), .out_valid(p_out_valid), .out_ready(out_ready),
    .taken(p_taken), .mispredict(p_mis), .redirect_pc(p_redir),
    .comp_code(p_code), .illegal(p_ill));

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .PIPE(0)) u_comb (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(c_pred),
    .in_valid(in_valid), .in_ready(c_in_ready), .decoded_f3(decoded_f3), .B(b),
    .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .in_pred_taken(in_pred_taken),
    .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
    .taken(c_taken), .mispredict(c_mis), .redirect_pc(c_redir),
    .comp_code(c_code), .illegal(c_ill));

  typedef struct packed {
    logic [7:0]  f3;
    logic        b;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pt;
  } req_t;

  typedef struct {
    logic        taken, mis, ill, train;
    logic [31:0] redir;
    logic [2:0]  code;
    int          idx;
  } exp_t;

  typedef struct {
    req_t        r;
    logic        taken, mis;
    logic [31:0] redir;
    logic [2:0]  code;
    logic        ill;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   bht_m [DEPTH];
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: spec rules applied directly to the request.
  function automatic exp_t ref_resolve(input req_t r);
    int   legal_bits [6] = '{0, 1, 4, 5, 6, 7};
    exp_t e;
    e.taken = 1'b0;
    e.ill   = 1'b0;
    e.code  = 3'd0;
    if (r.b) begin
      e.ill = r.f3[2] || r.f3[3] ||
              !(r.f3[0] || r.f3[1] || r.f3[4] || r.f3[5] || r.f3[6] || r.f3[7]);
      if (e.ill) e.code = 3'd7;
      else begin
        for (int k = 5; k >= 0; k--) if (r.f3[legal_bits[k]]) e.code = 3'(k);
        case (e.code)
          3'd0: e.taken = r.rs1 == r.rs2;
          3'd1: e.taken = r.rs1 != r.rs2;
          3'd2: e.taken = $signed(r.rs1) <  $signed(r.rs2);
          3'd3: e.taken = $signed(r.rs1) >= $signed(r.rs2);
          3'd4: e.taken = r.rs1 <  r.rs2;
          default: e.taken = r.rs1 >= r.rs2;
        endcase
      end
    end
    e.redir = e.taken ? r.pc + r.imm : r.pc + 32'd4;
    e.mis   = e.taken != r.pt;
    e.train = r.b && !e.ill;
    e.idx   = int'((r.pc >> 2) % DEPTH);
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.taken = v.taken; e.mis = v.mis; e.redir = v.redir;
    e.code  = v.code;  e.ill = v.ill;
    e.train = v.r.b && !v.ill;
    e.idx   = int'((v.r.pc >> 2) % DEPTH);
    return e;
  endfunction

  function automatic logic model_pred();
    return bht_m[int'((lookup_pc >> 2) % DEPTH)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
  endtask

  task automatic model_retire(input exp_t e);
    if (e.train) begin
      if (e.taken) bht_m[e.idx] = (bht_m[e.idx] == 3) ? 3 : bht_m[e.idx] + 1;
      else         bht_m[e.idx] = (bht_m[e.idx] == 0) ? 0 : bht_m[e.idx] - 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input req_t r);
    decoded_f3 = r.f3; b = r.b; rs1 = r.rs1; rs2 = r.rs2;
    pc = r.pc; imm = r.imm; in_pred_taken = r.pt;
  endtask

  task automatic scramble();
    decoded_f3 = 8'($urandom); b = 1'($urandom); rs1 = $urandom; rs2 = $urandom;
    pc = $urandom; imm = $urandom; in_pred_taken = 1'($urandom);
  endtask

  task automatic check_pipe(input string tag, input exp_t e);
    check({tag, " p_taken"}, p_taken, e.taken);
    check({tag, " p_mispredict"}, p_mis, e.mis);
    check({tag, " p_redirect_pc"}, p_redir, e.redir);
    check({tag, " p_comp_code"}, p_code, e.code);
    check({tag, " p_illegal"}, p_ill, e.ill);
  endtask

  task automatic check_comb(input string tag, input exp_t e);
    check({tag, " c_out_valid"}, c_out_valid, 1'b1);
    check({tag, " c_taken"}, c_taken, e.taken);
    check({tag, " c_mispredict"}, c_mis, e.mis);
    check({tag, " c_redirect_pc"}, c_redir, e.redir);
    check({tag, " c_comp_code"}, c_code, e.code);
    check({tag, " c_illegal"}, c_ill, e.ill);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  // One request through the registered unit, held for 'hold' cycles of
  // backpressure, then retired; prediction checked before and after.
  task automatic run_txn(input string tag, input req_t r, input exp_t e,
                         input int hold, input logic alias_lk);
    apply(r);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lookup_pc = alias_lk ? r.pc + DEPTH * 4 : r.pc;
    #1;
    check({tag, " in_ready idle"}, p_in_ready, 1'b1);
    check_comb(tag, e);
    cyc();
    in_valid  = 1'b0;
    scramble();
    out_ready = (hold == 0);
    #1;
    check({tag, " out_valid"}, p_out_valid, 1'b1);
    check_pipe(tag, e);
    for (int h = 0; h < hold; h++) begin
      check({tag, " in_ready held"}, p_in_ready, 1'b0);
      check({tag, " pred held"}, p_pred, model_pred());
      cyc();
      check({tag, " out_valid held"}, p_out_valid, 1'b1);
      check_pipe({tag, " held"}, e);
    end
    out_ready = 1'b1;
    #1;
    check({tag, " pred pre-retire"}, p_pred, model_pred());
    cyc();
    model_retire(e);
    check({tag, " out_valid drained"}, p_out_valid, 1'b0);
    check({tag, " pred post-retire"}, p_pred, model_pred());
  endtask

  req_t rq, rq2;
  exp_t ex, ex2;

  initial begin
    //            f3     b     rs1           rs2           pc            imm          pt      tk    mis   redirect     code  ill
    vecs[0]  = '{'{8'h01, 1'b1, 32'd5,        32'd5,        32'h100,      32'h20,      1'b0}, 1'b1, 1'b1, 32'h120,     3'd0, 1'b0};
    vecs[1]  = '{'{8'h10, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,      1'b1}, 1'b1, 1'b0, 32'h240,     3'd2, 1'b0};
    vecs[2]  = '{'{8'h40, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,      1'b1}, 1'b0, 1'b1, 32'h204,     3'd4, 1'b0};
    vecs[3]  = '{'{8'h04, 1'b1, 32'd1,        32'd1,        32'h300,      32'h8,       1'b0}, 1'b0, 1'b0, 32'h304,     3'd7, 1'b1};
    vecs[4]  = '{'{8'h01, 1'b0, 32'd5,        32'd5,        32'h10,       32'h20,      1'b1}, 1'b0, 1'b1, 32'h14,      3'd0, 1'b0};
    vecs[5]  = '{'{8'h80, 1'b1, 32'd3,        32'd3,        32'hFFFFFFF0, 32'h20,      1'b1}, 1'b1, 1'b0, 32'h10,      3'd5, 1'b0};
    vecs[6]  = '{'{8'h02, 1'b1, 32'd7,        32'd7,        32'h20,       32'h100,     1'b0}, 1'b0, 1'b0, 32'h24,      3'd1, 1'b0};
    vecs[7]  = '{'{8'h20, 1'b1, 32'd1,        32'hFFFFFFFF, 32'h20,       32'hFFFFFFF0, 1'b0}, 1'b1, 1'b1, 32'h10,     3'd3, 1'b0};
    vecs[8]  = '{'{8'h00, 1'b1, 32'd0,        32'd0,        32'h50,       32'h8,       1'b1}, 1'b0, 1'b1, 32'h54,      3'd7, 1'b1};
    vecs[9]  = '{'{8'h11, 1'b1, 32'd1,        32'd2,        32'h60,       32'h8,       1'b0}, 1'b0, 1'b0, 32'h64,      3'd0, 1'b0};
    vecs[10] = '{'{8'h09, 1'b1, 32'd4,        32'd4,        32'h70,       32'h8,       1'b0}, 1'b0, 1'b0, 32'h74,      3'd7, 1'b1};
    vecs[11] = '{'{8'h04, 1'b0, 32'd4,        32'd4,        32'h8,        32'h8,       1'b0}, 1'b0, 1'b0, 32'hC,       3'd0, 1'b0};

    lookup_pc = 32'h40;
    scramble();
    do_reset();
    #1;
    check("reset out_valid", p_out_valid, 1'b0);
    check("reset taken", p_taken, 1'b0);
    check("reset mispredict", p_mis, 1'b0);
    check("reset redirect_pc", p_redir, 32'h0);
    check("reset comp_code", p_code, 3'd0);
    check("reset illegal", p_ill, 1'b0);
    check("reset pred_taken", p_pred, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 12; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].r, from_vec(vecs[i]), i % 3, 1'b0);

    // Training, saturation at both ends, aliasing 0x40/0x80.
    do_reset();
    rq = '{8'h02, 1'b1, 32'd1, 32'd2, 32'h40, 32'h10, 1'b0};
    ex = ref_resolve(rq);
    run_txn("train t1", rq, ex, 0, 1'b0);
    run_txn("train t2", rq, ex, 0, 1'b0);
    run_txn("train t3", rq, ex, 0, 1'b0);
    check("pred 0x40 after taken x3", p_pred, 1'b1);
    rq2 = '{8'h02, 1'b1, 32'd9, 32'd9, 32'h80, 32'h10, 1'b1};
    ex2 = ref_resolve(rq2);
    for (int i = 0; i < 4; i++) run_txn("train nt", rq2, ex2, 0, 1'b1);
    lookup_pc = 32'h40;
    #1 check("pred 0x40 after alias not-taken x4", p_pred, 1'b0);
    run_txn("train t4", rq, ex, 0, 1'b0);
    check("pred 0x40 after one taken from 0", p_pred, 1'b0);
    run_txn("train t5", rq, ex, 0, 1'b0);
    check("pred 0x40 after two taken from 0", p_pred, 1'b1);

    // Backpressure with a second request waiting, then back-to-back drain.
    rq  = '{8'h01, 1'b1, 32'd3, 32'd3, 32'h44, 32'h100, 1'b0};
    rq2 = '{8'h20, 1'b1, 32'd2, 32'd5, 32'h48, 32'h100, 1'b1};
    ex  = ref_resolve(rq);
    ex2 = ref_resolve(rq2);
    lookup_pc = 32'h44;
    apply(rq); in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    apply(rq2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp in_ready", p_in_ready, 1'b0);
      check("bp pred unchanged", p_pred, model_pred());
      check_pipe("bp hold", ex);
      cyc();
    end
    out_ready = 1'b1;
    #1 check("bp in_ready on release", p_in_ready, 1'b1);
    cyc();
    model_retire(ex);
    in_valid = 1'b0;
    #1;
    check("bp second valid", p_out_valid, 1'b1);
    check_pipe("bp second", ex2);
    check("bp pred after first retire", p_pred, model_pred());
    cyc();
    model_retire(ex2);
    lookup_pc = 32'h48;
    #1 check("bp pred after second retire", p_pred, model_pred());

    // Flush kills a held result without training and blocks acceptance.
    rq = '{8'h01, 1'b1, 32'd6, 32'd6, 32'h40, 32'h8, 1'b0};
    lookup_pc = 32'h40;
    apply(rq); in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush in_ready", p_in_ready, 1'b0);
    check("flush comb out_valid", c_out_valid, 1'b0);
    check("flush comb in_ready", c_in_ready, 1'b0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush out_valid", p_out_valid, 1'b0);
    check("flush no training", p_pred, model_pred());

    // Reset in the middle of a held result.
    apply(rq); in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    #1;
    check("midreset out_valid", p_out_valid, 1'b0);
    check("midreset redirect_pc", p_redir, 32'h0);
    check("midreset taken", p_taken, 1'b0);
    check("midreset pred", p_pred, 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = int'($urandom_range(0, 8));
      case (sel)
        0: rq.f3 = 8'h01;  1: rq.f3 = 8'h02;  2: rq.f3 = 8'h10;
        3: rq.f3 = 8'h20;  4: rq.f3 = 8'h40;  5: rq.f3 = 8'h80;
        6: rq.f3 = 8'($urandom);
        default: rq.f3 = ($urandom_range(0, 1) != 0) ? 8'h04 : 8'h08;
      endcase
      rq.b   = $urandom_range(0, 7) != 0;
      rq.rs1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      rq.rs2 = ($urandom_range(0, 3) == 0) ? rq.rs1 :
               (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)));
      rq.pc  = $urandom & 32'hFFFF_FFFC;
      rq.imm = 32'($urandom_range(0, 255)) * 4 - 32'd512;
      rq.pt  = 1'($urandom);
      run_txn($sformatf("rnd%0d", n), rq, ref_resolve(rq),
              int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the RV32I core: evaluates all six B-type conditions from the one-hot funct3 decode, computes the redirect target, and flags mispredictions against the fetch-side prediction. It carries a direct-mapped bimodal history table (2-bit saturating counters) that fetch queries combinationally and that the unit trains when it retires a branch. It sits between the register-read and writeback/fetch-redirect logic, with optional output registering and a valid/ready handshake on both sides.

## Interface
- XLEN, 32: operand, PC and immediate width (≥ 8)
- BHT_DEPTH, 16: number of history counters; power of two, ≥ 2; IDX = log2(BHT_DEPTH)
- PIPE, 1: 1 = registered result (1-cycle latency); 0 = combinational result (0 latency)

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- lookup_pc  in  XLEN  fetch PC for prediction
- pred_taken  out  1  counter[lookup_pc[IDX+1:2]] ≥ 2 (combinational)
- in_valid  in  1  resolve request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- decoded_f3  in  8  one-hot funct3 (bit0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU)
- B  in  1  instruction is B-type
- rs1, rs2  in  XLEN  operands
- pc, imm  in  XLEN  branch PC, sign-extended offset
- in_pred_taken  in  1  prediction fetch used for this instruction
- flush  in  1  kill in-flight result
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- taken  out  1  resolved direction
- mispredict  out  1  taken != in_pred_taken
- redirect_pc  out  XLEN  correct next PC
- comp_code  out  3  0 ==, 1 !=, 2 <, 3 >=, 4 <u, 5 >=u, 7 illegal
- illegal  out  1  B=1 and decoded_f3 bit 2 or 3 set, or no legal bit set

## Operation
- comp_code: priority on first legal set bit of decoded_f3 gated by B; B=0 → comp_code 0, taken 0.
- Signed compares interpret rs1/rs2 as two's complement XLEN; unsigned as raw.
- illegal=1 forces taken=0; no BHT training.
- redirect_pc = taken ? pc+imm : pc+4, truncated mod 2^XLEN (wrap-around silent).
- mispredict computed for every result including B=0 (non-branch predicted taken → mispredict=1, redirect pc+4).
- BHT: BHT_DEPTH counters, index pc[IDX+1:2]; trained at result retirement (out_valid && out_ready && !flush) when B=1 and !illegal: taken → +1 saturating at 3, not-taken → −1 saturating at 0.
- Lookup and training same index same cycle: pred_taken returns pre-update value (no bypass).
- PIPE=1: single output register. in_ready = (!out_valid || out_ready) && !flush. Register captures on accept; out_valid drops on out_ready without new accept. Outputs stable while out_valid && !out_ready.
- PIPE=0: out_valid = in_valid && !flush; in_ready = out_ready && !flush; outputs follow inputs combinationally.
- flush: dominant. PIPE=1: out_valid=0 next cycle, no accept, no training this cycle. PIPE=0: suppresses out_valid and training this cycle.

## Timing
- Reset (rst high at edge): out_valid=0, taken=0, mispredict=0, redirect_pc=0, comp_code=0, illegal=0; all counters=1 (weakly not-taken) in the same edge; pred_taken=0 the cycle after.
- Reset mid-operation discards held result; no training on that edge.
- PIPE=1 latency: accept edge N → out_valid high in cycle N+1; throughput 1/cycle with out_ready held high.
- Training takes effect on pred_taken the cycle after retirement.
- in_ready is independent of in_valid (no combinational loop).

## Test plan
- Reset, PIPE=1: lookup any PC → pred_taken=0; BEQ rs1=rs2=5, pc=0x100, imm=0x20, in_pred_taken=0 → next cycle taken=1, mispredict=1, redirect_pc=0x120, comp_code=0.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1; BLT → taken=1 (code 2); BLTU → taken=0 (code 4), redirect_pc=pc+4.
- Training: two taken BNE at pc=0x40 retire → counter 1→2→3, pred_taken(0x40)=1; three not-taken → saturates at 0; pc=0x80 (alias at DEPTH 16) shares counter.
- Backpressure: out_ready=0 with result held, new in_valid → in_ready=0, outputs stable 3 cycles, counter unchanged until out_ready=1.
- Flush + illegal: flush with out_valid=1 → out_valid=0 next cycle, no training; B=1, decoded_f3=0x04 → illegal=1, comp_code=7, taken=0.
- Wrap: pc=0xFFFFFFF0, imm=0x20, taken → redirect_pc=0x10; PIPE=0 build: same result same cycle.
